// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game status serial link.
//   - frame header value and state word width
//   - field offsets of the 32-bit state word
//     {mstate[31:24], monHPrender[23:16], pHP[15:8], atkGage[7:0]}
//   - frame length (NBYTES), which depends on the CHECKSUM_EN macro
//   - FSM state types for the frame controller and the byte serializer
//   - helper that selects the header/payload byte for a given byte index
// Configuration macro: CHECKSUM_EN (adds an XOR checksum byte, NBYTES=6).
// ---------------------------------------------------------------------------
package game_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         STATE_W   = 32;

  localparam int MSTATE_LSB = 24;
  localparam int MONHP_LSB  = 16;
  localparam int PHP_LSB    = 8;
  localparam int ATK_LSB    = 0;

  localparam int IDX_W = 3;

`ifdef CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX         = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] LAST_PAYLOAD_IDX = IDX_W'(4);
  localparam logic [IDX_W-1:0] CSUM_IDX         = IDX_W'(5);

  typedef enum logic [1:0] {
    FRM_IDLE = 2'd0,
    FRM_RUN  = 2'd1,
    FRM_DONE = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    BYTE_IDLE  = 2'd0,
    BYTE_START = 2'd1,
    BYTE_DATA  = 2'd2,
    BYTE_STOP  = 2'd3
  } byte_state_t;

  // Header or payload byte for frame position idx (payload sent MSB first).
  function automatic logic [7:0] frame_byte(input logic [STATE_W-1:0] snap,
                                            input logic [IDX_W-1:0]   idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = FRAME_HDR;
      3'd1:    b = snap[MSTATE_LSB +: 8];
      3'd2:    b = snap[MONHP_LSB  +: 8];
      3'd3:    b = snap[PHP_LSB    +: 8];
      3'd4:    b = snap[ATK_LSB    +: 8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx
// 8N1 byte serializer: baud counter plus START/DATA/STOP shifter.
//
// state      | meaning
// -----------|------------------------------------------------------------
// BYTE_IDLE  | line idle high, waiting for load
// BYTE_START | start bit (0) for DIV clocks
// BYTE_DATA  | 8 data bits, LSB first, r_bit counts 0..7
// BYTE_STOP  | stop bit (1); a load on its last clock chains the next byte
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   load       in   start a byte with din (honoured in IDLE, or on the
//                   final stop-bit clock for back-to-back bytes)
//   din[7:0]   in   byte to send, sampled when load is accepted
//   tx         out  serial line, driven from a flop
//   byte_done  out  high during the final clock of the stop bit
//                   (combinational so the caller can chain without a gap)
// ---------------------------------------------------------------------------
module uart_byte_tx
  import game_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       byte_done
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

  byte_state_t   r_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_tx;

  byte_state_t   w_st_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_bit_n;
  logic [7:0]    w_sh_n;
  logic          w_tx_n;
  logic          w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st  <= BYTE_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
      r_tx  <= 1'b1;
    end else begin
      r_st  <= w_st_n;
      r_cnt <= w_cnt_n;
      r_bit <= w_bit_n;
      r_sh  <= w_sh_n;
      r_tx  <= w_tx_n;
    end
  end

  always_comb begin
    w_st_n  = r_st;
    w_cnt_n = (r_st == BYTE_IDLE) ? '0 : r_cnt + CW'(1);
    w_bit_n = r_bit;
    w_sh_n  = r_sh;
    w_tx_n  = r_tx;

    case (r_st)
      BYTE_IDLE: begin
        w_tx_n = 1'b1;
        if (load) begin
          w_st_n  = BYTE_START;
          w_sh_n  = din;
          w_cnt_n = '0;
          w_tx_n  = 1'b0;
        end
      end

      BYTE_START: begin
        if (w_tick) begin
          w_st_n  = BYTE_DATA;
          w_cnt_n = '0;
          w_bit_n = '0;
          w_tx_n  = r_sh[0];
        end
      end

      BYTE_DATA: begin
        if (w_tick) begin
          w_cnt_n = '0;
          if (r_bit == 3'd7) begin
            w_st_n = BYTE_STOP;
            w_tx_n = 1'b1;
          end else begin
            w_bit_n = r_bit + 3'd1;
            // Shift right so the next data bit is always at r_sh[0].
            w_sh_n  = {1'b0, r_sh[7:1]};
            w_tx_n  = r_sh[1];
          end
        end
      end

      BYTE_STOP: begin
        if (w_tick) begin
          w_cnt_n = '0;
          if (load) begin
            w_st_n = BYTE_START;
            w_sh_n = din;
            w_tx_n = 1'b0;
          end else begin
            w_st_n = BYTE_IDLE;
            w_tx_n = 1'b1;
          end
        end
      end

      default: begin
        w_st_n  = BYTE_IDLE;
        w_cnt_n = '0;
        w_tx_n  = 1'b1;
      end
    endcase
  end

  assign tx        = r_tx;
  assign byte_done = (r_st == BYTE_STOP) && w_tick;

endmodule

// File: rtl/state_uart_tx.sv
// ---------------------------------------------------------------------------
// state_uart_tx
// Sends the 32-bit game state word as a framed 8N1 UART burst:
//   0xA5, state[31:24], state[23:16], state[15:8], state[7:0] [, checksum]
// The state word is snapshotted when a send is accepted and held for the
// whole frame. Optional macro CHECKSUM_EN appends the XOR of the four
// payload bytes as a 6th byte.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// FRM_IDLE | line idle, accepts send
// FRM_RUN  | frame in progress (busy=1), bytes chained by r_idx
// FRM_DONE | one-cycle done pulse; send is accepted here as well
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   send         in   frame request, acted on only when busy=0
//   state[31:0]  in   game state word
//   busy         out  frame in progress (registered)
//   done         out  one-cycle pulse after the final stop bit (registered)
//   tx           out  serial line, idle high (registered)
// ---------------------------------------------------------------------------
module state_uart_tx
  import game_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               send,
  input  logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               done,
  output logic               tx
);

  localparam int DIV = CLK_HZ / BAUD;

  frame_state_t       r_fsm;
  frame_state_t       w_fsm_n;
  logic [STATE_W-1:0] r_snap;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_last;
  logic               w_next_load;
  logic               w_load;
  logic [IDX_W-1:0]   w_nidx;
  logic [7:0]         w_next_byte;
  logic [7:0]         w_din;
  logic               w_tx;
  logic               w_byte_done;

  // DONE behaves like IDLE for acceptance so a held send chains frames.
  assign w_accept    = send && (r_fsm != FRM_RUN);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_next_load = (r_fsm == FRM_RUN) && w_byte_done && !w_last;
  assign w_load      = w_accept || w_next_load;
  assign w_nidx      = r_idx + IDX_W'(1);

`ifdef CHECKSUM_EN
  logic [7:0] r_csum;

  assign w_next_byte = (w_nidx == CSUM_IDX) ? r_csum : frame_byte(r_snap, w_nidx);

  // Accumulated as each payload byte is handed to the serializer, so it is
  // complete by the time the checksum byte itself is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_next_load && (w_nidx <= LAST_PAYLOAD_IDX)) begin
      r_csum <= r_csum ^ w_din;
    end
  end
`else
  assign w_next_byte = frame_byte(r_snap, w_nidx);
`endif

  assign w_din = w_accept ? FRAME_HDR : w_next_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_snap <= state;
      r_idx  <= '0;
    end else if (w_next_load) begin
      r_idx  <= w_nidx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm  <= FRM_IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_n;
      r_busy <= (w_fsm_n == FRM_RUN);
      r_done <= (w_fsm_n == FRM_DONE);
    end
  end

  always_comb begin
    w_fsm_n = r_fsm;
    case (r_fsm)
      FRM_IDLE: if (send) w_fsm_n = FRM_RUN;
      FRM_RUN:  if (w_byte_done && w_last) w_fsm_n = FRM_DONE;
      FRM_DONE: w_fsm_n = send ? FRM_RUN : FRM_IDLE;
      default:  w_fsm_n = FRM_IDLE;
    endcase
  end

  uart_byte_tx #(
    .DIV(DIV)
  ) u_byte_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .din       (w_din),
    .tx        (w_tx),
    .byte_done (w_byte_done)
  );

  assign busy = r_busy;
  assign done = r_done;
  assign tx   = w_tx;

endmodule
